// File: rtl/pwm_peripheral.sv
// Shared 8-bit PWM generator driving 16 outputs, each gated by enable and PWM-select bits.
// Latency: outputs and pwm_period_start registered, 1 clk after any input or count change.
// Backpressure: none; free-running and always accepts register values.
module pwm_peripheral #(
    parameter int unsigned CLK_DIV = 13
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] en_reg_out_7_0,
    input  logic [7:0] en_reg_out_15_8,
    input  logic [7:0] en_reg_pwm_7_0,
    input  logic [7:0] en_reg_pwm_15_8,
    input  logic [7:0] pwm_duty_cycle,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic       pwm_period_start
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    logic [7:0]  prescaler;
    logic [7:0]  pwm_count;
    logic [7:0]  duty_active;
    logic        step;
    logic        pwm_sig;
    logic [15:0] en_all;
    logic [15:0] pwm_all;
    logic [15:0] out_nxt;

    // With CLK_DIV==1 DIV_LAST is 0, so prescaler stays 0 and every clk is a step.
    assign step = (prescaler == DIV_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler   <= 8'd0;
            pwm_count   <= 8'd0;
            duty_active <= 8'd0;
        end else begin
            prescaler <= step ? 8'd0 : prescaler + 8'd1;
            if (step) begin
                pwm_count <= pwm_count + 8'd1;
                // Shadow load only at the wrap so a period is never cut short.
                if (pwm_count == 8'hFF) begin
                    duty_active <= pwm_duty_cycle;
                end
            end
        end
    end

    // 0xFF is special-cased so full duty never shows the single low count.
    assign pwm_sig = (duty_active == 8'hFF) ? 1'b1 : (pwm_count < duty_active);

    assign en_all  = {en_reg_out_15_8, en_reg_out_7_0};
    assign pwm_all = {en_reg_pwm_15_8, en_reg_pwm_7_0};
    assign out_nxt = en_all & (~pwm_all | {16{pwm_sig}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            uo_out           <= 8'd0;
            uio_out          <= 8'd0;
            pwm_period_start <= 1'b0;
        end else begin
            {uio_out, uo_out} <= out_nxt;
            // Same edge that registers the first count-0 sample of the period.
            pwm_period_start  <= (pwm_count == 8'd0) && (prescaler == 8'd0);
        end
    end

endmodule

// File: tb/tb_pwm_peripheral.sv
// Directed bench for pwm_peripheral at CLK_DIV=13 (period 3328 clks).
module tb_pwm_peripheral;

    localparam int PERIOD = 3328;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] en_lo, en_hi, pwm_lo, pwm_hi, duty;
    logic [7:0] uo, uio;
    logic       ps;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pwm_peripheral #(.CLK_DIV(13)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .en_reg_out_7_0   (en_lo),
        .en_reg_out_15_8  (en_hi),
        .en_reg_pwm_7_0   (pwm_lo),
        .en_reg_pwm_15_8  (pwm_hi),
        .pwm_duty_cycle   (duty),
        .uo_out           (uo),
        .uio_out          (uio),
        .pwm_period_start (ps)
    );

    typedef struct {
        logic [7:0] en_lo;
        logic [7:0] en_hi;
        logic [7:0] pwm_lo;
        logic [7:0] pwm_hi;
        logic [7:0] exp_uo;
        logic [7:0] exp_uio;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Waits for the next pwm_period_start sample; n = negedges waited, -1 on timeout.
    task automatic wait_pulse(input int limit, output int n);
        n = -1;
        for (int k = 1; k <= limit; k++) begin
            @(negedge clk);
            if (ps === 1'b1) begin
                n = k;
                break;
            end
        end
    endtask

    // Called on the sample where pwm_period_start is high; returns on the next one.
    task automatic measure(input string name, input int exp_hi, input int chg_idx,
                           input logic [7:0] chg_duty);
        int hi = 0;
        int first_low = -1;
        int early = 0;
        for (int i = 0; i < PERIOD; i++) begin
            if (uo[0] === 1'b1) hi++;
            else if (first_low < 0) first_low = i;
            if (i == chg_idx) duty = chg_duty;
            @(negedge clk);
            if (i < PERIOD - 1 && ps !== 1'b0) early++;
        end
        if (first_low < 0) first_low = PERIOD;
        check({name, " high clks"}, hi, exp_hi);
        check({name, " first low"}, first_low, exp_hi);
        check({name, " stray period_start"}, early, 0);
        check({name, " next period_start"}, ps, 1);
    endtask

    vec_t vecs[7];
    int   n;

    initial begin
        vecs[0] = '{8'hFF, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00};
        vecs[1] = '{8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'hFF};
        vecs[2] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00};
        vecs[3] = '{8'hA5, 8'h3C, 8'h0F, 8'hF0, 8'hA0, 8'h0C};
        vecs[4] = '{8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00};
        vecs[5] = '{8'h81, 8'h18, 8'h01, 8'h10, 8'h80, 8'h08};
        vecs[6] = '{8'h5A, 8'hC3, 8'hA5, 8'h3C, 8'h5A, 8'hC3};

        en_lo = 8'h00; en_hi = 8'h00; pwm_lo = 8'h00; pwm_hi = 8'h00; duty = 8'h00;
        repeat (3) @(negedge clk);
        check("reset uo", uo, 8'h00);
        check("reset uio", uio, 8'h00);
        check("reset period_start", ps, 1'b0);

        // Static-high enable, one clk latency; first period starts right after release.
        rst_n = 1'b1;
        en_lo = 8'hFF;
        @(negedge clk);
        check("static uo", uo, 8'hFF);
        check("static uio", uio, 8'h00);
        check("first period_start", ps, 1'b1);
        @(negedge clk);
        check("period_start one clk", ps, 1'b0);

        // duty_active is 0 in the first period, so PWM-mode bits read 0.
        foreach (vecs[v]) begin
            en_lo = vecs[v].en_lo; en_hi = vecs[v].en_hi;
            pwm_lo = vecs[v].pwm_lo; pwm_hi = vecs[v].pwm_hi;
            @(negedge clk);
            check($sformatf("vec%0d uo", v), uo, vecs[v].exp_uo);
            check($sformatf("vec%0d uio", v), uio, vecs[v].exp_uio);
        end

        en_lo = 8'h01; pwm_lo = 8'h01; en_hi = 8'h00; pwm_hi = 8'h00; duty = 8'h80;
        wait_pulse(4000, n);
        check("boundary reached", (n > 0), 1);
        check("high aligned with period_start", uo[0], 1'b1);
        measure("duty80", 1664, 5, 8'h00);
        measure("duty00", 0, 5, 8'hFF);
        measure("dutyFF", PERIOD, 5, 8'h40);
        measure("duty40 change mid", 832, 1300, 8'hC0);
        measure("dutyC0", 2496, 5, 8'h80);

        // Mixed static/PWM/disabled on the upper byte during a 0x80 period.
        en_hi = 8'hF0; pwm_hi = 8'h30; en_lo = 8'h0F; pwm_lo = 8'h00;
        @(negedge clk);
        check("mix high uio", uio, 8'hF0);
        check("mix high uo", uo, 8'h0F);
        repeat (1700) @(negedge clk);
        check("mix low uio", uio, 8'hC0);
        check("mix low uo", uo, 8'h0F);
        wait_pulse(4000, n);
        check("mix period length", n, 1627);

        // Reset asserted inside the high phase.
        repeat (100) @(negedge clk);
        check("pre-reset uio", uio, 8'hF0);
        #2 rst_n = 1'b0;
        #1;
        check("async reset uo", uo, 8'h00);
        check("async reset uio", uio, 8'h00);
        check("async reset period_start", ps, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post-reset period_start", ps, 1'b1);
        check("post-reset uio duty 0", uio, 8'hC0);
        check("post-reset uo", uo, 8'h0F);
        @(negedge clk);
        check("post-reset period_start drop", ps, 1'b0);
        repeat (100) @(negedge clk);
        check("post-reset mid uio", uio, 8'hC0);
        wait_pulse(4000, n);
        check("post-reset period length", n, 3227);
        check("post-reset new duty uio", uio, 8'hF0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
